// File: rtl/audio_output_serializer.sv
// Bit-serial audio output stage: fetches words from the delay buffer and streams them one bit per clock.
// Optional build macro AUDIO_OUT_MSB_FIRST_EN selects MSB-first serialisation (default is LSB first).
module audio_output_serializer #(
  parameter int SAMPLE_WIDTH = 16,
  parameter int ADDR_WIDTH   = 16,
  parameter int RD_LATENCY   = 1
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    enable,
  input  logic [1:0]              rate_sel,
  input  logic [ADDR_WIDTH-1:0]   start_addr,
  input  logic [ADDR_WIDTH-1:0]   end_addr,
  input  logic [SAMPLE_WIDTH-1:0] rd_data,
  output logic                    rd_en,
  output logic [ADDR_WIDTH-1:0]   rd_addr,
  output logic                    pdm_out,
  output logic                    sample_strobe,
  output logic                    wrap_pulse,
  output logic                    busy,
  output logic [1:0]              dbg_state_o
);

  localparam int CNT_W = $clog2(SAMPLE_WIDTH);
  localparam int SUM_W = ADDR_WIDTH + 1;
  localparam logic [CNT_W-1:0] LAST_CNT   = CNT_W'(SAMPLE_WIDTH - 1);
  localparam logic [CNT_W-1:0] PF_CNT     = CNT_W'(RD_LATENCY + 1);
  localparam logic [2:0]       PRIME_LAST = 3'(RD_LATENCY);

  typedef enum logic [1:0] {IDLE = 2'd0, PRIME = 2'd1, RUN = 2'd2} state_t;

  state_t                  state_q, state_d;
  logic                    rd_en_q, pdm_q, strobe_q, wrap_q;
  logic [ADDR_WIDTH-1:0]   rd_addr_q, start_q, end_q;
  logic [1:0]              step_q;
  logic [2:0]              wait_q;
  logic [CNT_W-1:0]        bit_cnt_q, bit_idx;
  logic [SAMPLE_WIDTH-1:0] shift_q, pf_q;
  logic [SUM_W-1:0]        sum;
  logic                    wrap_hit;
  logic [ADDR_WIDTH-1:0]   next_addr;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (enable) state_d = PRIME;
      PRIME:   if (wait_q == PRIME_LAST) state_d = RUN;
      RUN:     if ((bit_cnt_q == LAST_CNT) && !enable) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy        = (state_q != IDLE);
    dbg_state_o = state_q;
  end

  // Overflow out of ADDR_WIDTH bits counts as leaving the window, as does passing end_q.
  always_comb begin
    sum       = {1'b0, rd_addr_q} + SUM_W'(step_q) + SUM_W'(1);
    wrap_hit  = sum[ADDR_WIDTH] || (sum[ADDR_WIDTH-1:0] > end_q);
    next_addr = wrap_hit ? start_q : sum[ADDR_WIDTH-1:0];
`ifdef AUDIO_OUT_MSB_FIRST_EN
    bit_idx   = LAST_CNT - bit_cnt_q;
`else
    bit_idx   = bit_cnt_q;
`endif
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_en_q   <= 1'b0;
      rd_addr_q <= '0;
      pdm_q     <= 1'b0;
      strobe_q  <= 1'b0;
      wrap_q    <= 1'b0;
      start_q   <= '0;
      end_q     <= '0;
      step_q    <= '0;
      wait_q    <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      pf_q      <= '0;
    end else begin
      rd_en_q  <= 1'b0;
      strobe_q <= 1'b0;
      wrap_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          pdm_q  <= 1'b0;
          wait_q <= '0;
          if (enable) begin
            start_q   <= start_addr;
            end_q     <= end_addr;
            step_q    <= rate_sel;
            rd_en_q   <= 1'b1;
            rd_addr_q <= start_addr;
          end
        end
        PRIME: begin
          pdm_q  <= 1'b0;
          wait_q <= wait_q + 3'd1;
          if (wait_q == PRIME_LAST) begin
            shift_q   <= rd_data;
            strobe_q  <= 1'b1;
            bit_cnt_q <= '0;
          end
        end
        RUN: begin
          pdm_q <= shift_q[bit_idx];
          if (bit_cnt_q == '0) begin
            rd_en_q   <= 1'b1;
            rd_addr_q <= next_addr;
            wrap_q    <= wrap_hit;
          end
          if (bit_cnt_q == PF_CNT) pf_q <= rd_data;
          // On a drain boundary the prefetched word is simply dropped.
          if (bit_cnt_q == LAST_CNT) begin
            bit_cnt_q <= '0;
            if (enable) begin
              shift_q  <= pf_q;
              strobe_q <= 1'b1;
              step_q   <= rate_sel;
            end
          end else begin
            bit_cnt_q <= bit_cnt_q + 1'b1;
          end
        end
        default: pdm_q <= 1'b0;
      endcase
    end
  end

  assign rd_en         = rd_en_q;
  assign rd_addr       = rd_addr_q;
  assign pdm_out       = pdm_q;
  assign sample_strobe = strobe_q;
  assign wrap_pulse    = wrap_q;

endmodule

// File: tb/tb_audio_output_serializer.sv
// Directed bench for audio_output_serializer: fixed-latency buffer model, fetch-address and bit-stream scoreboards.
module tb_audio_output_serializer;

  localparam int LAT = 3;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        enable;
  logic [1:0]  rate_sel;
  logic [15:0] start_addr, end_addr;
  logic [15:0] rd_data;
  logic        rd_en, pdm_out, sample_strobe, wrap_pulse, busy;
  logic [15:0] rd_addr;
  logic [1:0]  dbg_state;

  int tests_run = 0;
  int fails = 0;
  int cyc = 0;
  bit streaming = 1'b0;
  int last_strobe = 0;

  logic [16:0] exp_addr_q[$];
  logic [0:0]  exp_bit_q[$];

  audio_output_serializer #(
    .SAMPLE_WIDTH(16), .ADDR_WIDTH(16), .RD_LATENCY(LAT)
  ) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .rate_sel(rate_sel),
    .start_addr(start_addr), .end_addr(end_addr), .rd_data(rd_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .pdm_out(pdm_out),
    .sample_strobe(sample_strobe), .wrap_pulse(wrap_pulse), .busy(busy),
    .dbg_state_o(dbg_state)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Delay-buffer model: word = address, except two special words for the bit-order test.
  function automatic logic [15:0] mem_word(input logic [15:0] a);
    if (a == 16'h0100) return 16'h8001;
    if (a == 16'h0101) return 16'hC000;
    return a;
  endfunction

  logic [LAT-1:0] pipe_v = '0;
  logic [15:0]    pipe_d [LAT];
  always @(posedge clk) begin
    pipe_v    <= {pipe_v[LAT-2:0], rd_en};
    pipe_d[0] <= mem_word(rd_addr);
    for (int i = 1; i < LAT; i++) pipe_d[i] <= pipe_d[i-1];
  end
  assign rd_data = pipe_v[LAT-1] ? pipe_d[LAT-1] : 16'hA5A5;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_word(input logic [15:0] w);
`ifdef AUDIO_OUT_MSB_FIRST_EN
    for (int i = 15; i >= 0; i--) exp_bit_q.push_back(w[i]);
`else
    for (int i = 0; i < 16; i++) exp_bit_q.push_back(w[i]);
`endif
  endtask

  // Monitor: fetch addresses/wrap flags, serial bits, and strobe spacing.
  always @(negedge clk) begin
    logic [16:0] ea;
    if (reset_n === 1'b1) begin
      if (rd_en) begin
        check("rd_en_expected", 32'(exp_addr_q.size() > 0), 1);
        if (exp_addr_q.size() > 0) begin
          ea = exp_addr_q.pop_front();
          check("rd_addr", rd_addr, ea[15:0]);
          check("wrap_pulse", wrap_pulse, ea[16]);
        end
      end else begin
        check("wrap_without_rd_en", wrap_pulse, 0);
      end
      if (streaming && exp_bit_q.size() > 0) check("pdm_bit", pdm_out, exp_bit_q.pop_front());
      if (sample_strobe) begin
        if (streaming) check("strobe_interval", cyc - last_strobe, 16);
        streaming   = 1'b1;
        last_strobe = cyc;
      end
    end
  end

  task automatic wait_strobe(output bit ok, output int sc);
    ok = 1'b0;
    sc = 0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (sample_strobe) begin
        ok = 1'b1;
        sc = cyc;
        break;
      end
    end
    check("strobe_seen", ok, 1);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_rd_en"}, rd_en, 0);
    check({tag, "_rd_addr"}, rd_addr, 0);
    check({tag, "_pdm"}, pdm_out, 0);
    check({tag, "_strobe"}, sample_strobe, 0);
    check({tag, "_wrap"}, wrap_pulse, 0);
    check({tag, "_busy"}, busy, 0);
  endtask

  // One play session: three words streamed, enable dropped at bit 5 of the third word.
  task automatic run_session(input logic [15:0] s, input logic [15:0] e, input logic [1:0] r,
                             input logic [16:0] a0, input logic [16:0] a1,
                             input logic [16:0] a2, input logic [16:0] a3,
                             input logic [15:0] w0, input logic [15:0] w1,
                             input logic [15:0] w2, input bit rel);
    bit ok;
    int sc, ec;
    exp_addr_q.push_back(a0); exp_addr_q.push_back(a1);
    exp_addr_q.push_back(a2); exp_addr_q.push_back(a3);
    push_word(w0); push_word(w1); push_word(w2);
    streaming = 1'b0;
    @(negedge clk);
    start_addr = s; end_addr = e; rate_sel = r; enable = 1'b1;
    if (rel) reset_n = 1'b1;
    ec = cyc + 1;
    wait_strobe(ok, sc);
    if (ok) begin
      check("first_strobe_latency", sc - ec, LAT + 1);
      @(negedge clk);
      start_addr = ~s; end_addr = ~e;
      repeat (37) @(negedge clk);
      enable = 1'b0;
      repeat (11) @(negedge clk);
      check("drain_pdm_zero", pdm_out, 0);
      check("drain_busy_low", busy, 0);
      repeat (20) @(negedge clk);
    end else begin
      enable = 1'b0;
      repeat (40) @(negedge clk);
    end
    check("addr_queue_empty", exp_addr_q.size(), 0);
    check("bit_queue_empty", exp_bit_q.size(), 0);
    exp_addr_q.delete();
    exp_bit_q.delete();
  endtask

  initial begin
    bit ok;
    int sc;
    reset_n = 1'b0; enable = 1'b0; rate_sel = 2'd0; start_addr = '0; end_addr = '0;
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    @(negedge clk) reset_n = 1'b1;
    repeat (4) @(negedge clk);
    check("idle_no_rd_en", rd_en, 0);
    check("idle_busy", busy, 0);

    // Sequential window, step 1.
    run_session(16'h0010, 16'h00FF, 2'd0, {1'b0, 16'h0010}, {1'b0, 16'h0011},
                {1'b0, 16'h0012}, {1'b0, 16'h0013}, 16'h0010, 16'h0011, 16'h0012, 1'b0);
    // Step 4 inside a short window: 0,4,8 then wrap to 0.
    run_session(16'h0000, 16'h000A, 2'd3, {1'b0, 16'h0000}, {1'b0, 16'h0004},
                {1'b0, 16'h0008}, {1'b1, 16'h0000}, 16'h0000, 16'h0004, 16'h0008, 1'b0);
    // Address sum overflows 16 bits on every fetch.
    run_session(16'hFFFE, 16'hFFFF, 2'd2, {1'b0, 16'hFFFE}, {1'b1, 16'hFFFE},
                {1'b1, 16'hFFFE}, {1'b1, 16'hFFFE}, 16'hFFFE, 16'hFFFE, 16'hFFFE, 1'b0);
    // Bit-order words 0x8001 / 0xC000.
    run_session(16'h0100, 16'h0101, 2'd0, {1'b0, 16'h0100}, {1'b0, 16'h0101},
                {1'b1, 16'h0100}, {1'b0, 16'h0101}, 16'h8001, 16'hC000, 16'h8001, 1'b0);

    // Reset asserted mid-word, then re-prime from start_addr with enable held high.
    exp_addr_q.push_back({1'b0, 16'h0020});
    exp_addr_q.push_back({1'b0, 16'h0021});
    exp_addr_q.push_back({1'b0, 16'h0022});
    push_word(16'h0020);
    streaming = 1'b0;
    @(negedge clk);
    start_addr = 16'h0020; end_addr = 16'h002F; rate_sel = 2'd0; enable = 1'b1;
    wait_strobe(ok, sc);
    repeat (22) @(negedge clk);
    check("pre_reset_busy", busy, 1);
    check("pre_reset_addr_q", exp_addr_q.size(), 0);
    reset_n = 1'b0;
    #1;
    check_idle_outputs("async_reset");
    exp_addr_q.delete();
    exp_bit_q.delete();
    repeat (2) @(negedge clk);
    check_idle_outputs("held_reset");
    run_session(16'h0020, 16'h002F, 2'd0, {1'b0, 16'h0020}, {1'b0, 16'h0021},
                {1'b0, 16'h0022}, {1'b0, 16'h0023}, 16'h0020, 16'h0021, 16'h0022, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
